osc_freq_meter: RTL

Multi-channel digital frequency meter for the relaxation-oscillator macro. It samples the comparator outputs of up to `CHANNELS` on-chip oscillators and counts their rising edges over a programmable gate window of `clk` cycles. At the end of each window it latches the per-channel counts into readable result registers. It sits between the analog oscillator outputs (routed in as digital levels) and the `uo_out` byte bus, and supports single-shot and gap-free continuous measurement.

---
 rtl/osc_freq_meter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/osc_freq_meter.sv
// osc_freq_meter: multi-channel rising-edge counter over a programmable gate
// window of clk cycles, with saturating counters, latched results and a
// byte-wide readback mux. Single-shot or gap-free continuous windows.
module osc_freq_meter #(
    parameter  int CHANNELS = 2,
    parameter  int CNT_W    = 16,
    parameter  int GATE_W   = 16,
    localparam int NBYTES   = CNT_W / 8,
    localparam int BSEL_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                ena_i,
    input  logic [CHANNELS-1:0] osc_in_i,
    input  logic                start_i,
    input  logic                continuous_i,
    input  logic [GATE_W-1:0]   gate_len_i,
    input  logic [2:0]          ch_sel_i,
    input  logic [BSEL_W-1:0]   byte_sel_i,
    output logic [7:0]          result_byte_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic [CHANNELS-1:0] overflow_o
);

    typedef enum logic {IDLE, GATE} state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                         state_q, state_d;
    logic [GATE_W-1:0]              gate_q, gate_d;
    logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0]            sat_q, sat_d;
    logic [CHANNELS-1:0][CNT_W-1:0] res_q, res_d;
    logic [CHANNELS-1:0]            ovf_q, ovf_d;
    logic                           rdy_q, rdy_d;
    logic [CHANNELS-1:0]            s1_q, s2_q, prev_q;
    logic [CHANNELS-1:0]            rise;
    logic [CHANNELS-1:0][CNT_W-1:0] inc;
    logic [CHANNELS-1:0]            inc_sat;

    // Two-flop synchronizer plus one delay flop for rising-edge detection
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= osc_in_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign rise = s2_q & ~prev_q;

    // Per-channel saturating increment; the flag marks an edge lost to saturation
    always_comb begin
        inc     = cnt_q;
        inc_sat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (rise[c]) begin
                if (cnt_q[c] == CNT_MAX) inc_sat[c] = 1'b1;
                else                     inc[c]     = cnt_q[c] + 1'b1;
            end
        end
    end

    // Window FSM; the last gate cycle latches results and may reload in place
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        rdy_d   = rdy_q;
        case (state_q)
            IDLE: begin
                if (start_i && ena_i) begin
                    state_d = GATE;
                    cnt_d   = '0;
                    sat_d   = '0;
                    gate_d  = gate_len_i;
                    rdy_d   = 1'b0;
                end
            end
            GATE: begin
                if (!ena_i) begin
                    // abandon the window; results and ready stay as they are
                    state_d = IDLE;
                end else if (gate_q != '0) begin
                    gate_d = gate_q - 1'b1;
                    cnt_d  = inc;
                    sat_d  = sat_q | inc_sat;
                end else begin
                    res_d = inc;
                    ovf_d = sat_q | inc_sat;
                    rdy_d = 1'b1;
                    if (continuous_i) begin
                        // back-to-back window: this cycle's edge already went into res_d
                        cnt_d  = '0;
                        sat_d  = '0;
                        gate_d = gate_len_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            gate_q  <= '0;
            cnt_q   <= '0;
            sat_q   <= '0;
            res_q   <= '0;
            ovf_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            rdy_q   <= rdy_d;
        end
    end

    // Byte readback; unmatched channel or byte selects read as zero
    always_comb begin
        result_byte_o = 8'h00;
        for (int c = 0; c < CHANNELS; c++) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (ch_sel_i == 3'(c) && byte_sel_i == BSEL_W'(b))
                    result_byte_o = res_q[c][8*b +: 8];
            end
        end
    end

    assign busy_o     = (state_q == GATE);
    assign ready_o    = rdy_q;
    assign overflow_o = ovf_q;

endmodule
